// File: rtl/bus_master_if.sv
// bus_master_if: turns one CPU access into a request/grant/strobe/ready bus transaction with a timeout watchdog
module bus_master_if #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rdy_,
  output logic              cpu_err,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic req_n_q, req_n_d, as_n_q, as_n_d, rdy_n_q, rdy_n_d, err_q, err_d, busy_q, busy_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // next state and registered outputs; done/err pulses default low so they self-clear
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_n_d = req_n_q;
    as_n_d  = as_n_q;
    rdy_n_d = 1'b1;
    err_d   = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (!cpu_as_ && rdy_n_q && !err_q) begin
        rw_d    = cpu_rw;
        addr_d  = cpu_addr;
        wdata_d = cpu_wr_data;
        req_n_d = 1'b0;
        state_d = REQ;
      end
      REQ: if (!bus_grnt_) begin
        as_n_d  = 1'b0;
        state_d = ACCESS;
      end
      ACCESS: begin
        as_n_d  = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (!bus_rdy_) begin
        rdata_d = rw_q ? bus_rd_data : rdata_q;
        rdy_n_d = 1'b0;
        req_n_d = 1'b1;
        state_d = IDLE;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d   = 1'b1;
        req_n_d = 1'b1;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      req_n_q <= 1'b1;
      as_n_q  <= 1'b1;
      rdy_n_q <= 1'b1;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_n_q <= req_n_d;
      as_n_q  <= as_n_d;
      rdy_n_q <= rdy_n_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign cpu_rd_data = rdata_q;
  assign cpu_rdy_    = rdy_n_q;
  assign cpu_err     = err_q;
  assign busy        = busy_q;
  assign bus_req_    = req_n_q;
  assign bus_as_     = as_n_q;
  assign bus_rw      = rw_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wdata_q;
endmodule
